// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage load/store to ready/valid SRAM bus bridge with byte strobes and load extension.
// Optional macro DMEM_BRIDGE_TIMEOUT_EN adds a bus wait timeout that aborts with bus_err_m.
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_m,
    output logic [31:0] rdata_m,
    output logic        misalign_m,
    output logic        bus_err_m,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t      state;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        mis;
    logic        expire;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;
    logic [31:0] sh;
    logic [31:0] ext;
    logic [1:0]  sz;
    // funct3[1:0] gives the access size; undefined codes fall into the word case
    assign sz = req_funct3[1:0];
    assign mis = sz == 2'b00 ? 1'b0 : sz == 2'b01 ? req_addr[0] : |req_addr[1:0];
    assign strb_n = sz == 2'b00 ? 4'b0001 << req_addr[1:0] : sz == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_n = sz == 2'b00 ? {4{req_wdata[7:0]}} : sz == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign sh = bus_rdata >> {off, 3'b000};
    assign ext = f3[1:0] == 2'b00 ? {{24{!f3[2] & sh[7]}}, sh[7:0]} :
                 f3[1:0] == 2'b01 ? {{16{!f3[2] & sh[15]}}, sh[15:0]} : bus_rdata;
    assign stall_m = !rst && (state == BUS || (state == IDLE && req_valid && !mis));
    assign misalign_m = state == IDLE && req_valid && mis;
    assign rdata_m = state == DONE ? rdata : 32'd0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt;
    assign expire = state == BUS && !bus_ready && cnt == 16'(TIMEOUT_CYCLES - 1);
    // wait counter restarts on every BUS entry; error flag lasts only the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bus_err_m <= 1'b0;
        end else begin
            cnt       <= state == BUS ? cnt + 16'd1 : 16'd0;
            bus_err_m <= expire;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
    assign bus_err_m = 1'b0;
`endif
    // request FSM: latch bus fields in IDLE, hold them through BUS, capture load data on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            rdata     <= '0;
            f3        <= '0;
            off       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && !mis) begin
                    state     <= BUS;
                    bus_valid <= 1'b1;
                    bus_write <= req_write;
                    bus_addr  <= {req_addr[31:2], 2'b00};
                    bus_wdata <= wdata_n;
                    bus_wstrb <= req_write ? strb_n : 4'b0000;
                    f3        <= req_funct3;
                    off       <= req_addr[1:0];
                end
                BUS: if (bus_ready || expire) begin
                    state     <= DONE;
                    bus_valid <= 1'b0;
                    rdata     <= (bus_write || !bus_ready) ? 32'd0 : ext;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Memory-stage data-access bridge between the pipelined CPU's memory stage and a wait-state-capable ready/valid data SRAM bus. It converts a single load/store request into a word-aligned bus transaction with byte strobes. It returns sign- or zero-extended load data and holds the pipeline with `stall_m` until the access completes. Misaligned accesses are rejected without bus activity.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles waited for `bus_ready` before abort (only with timeout feature).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: memory stage holds a load or store.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `stall_m` out 1: hold fetch through memory stage this cycle.
- `rdata_m` out 32: extended load data, valid in the DONE cycle.
- `misalign_m` out 1: request rejected as misaligned.
- `bus_err_m` out 1: access aborted by timeout.
- `bus_valid` out 1: transaction request.
- `bus_write` out 1: transaction is a write.
- `bus_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_wstrb` out 4: byte enables, 0000 for loads.
- `bus_ready` in 1: slave accepts/completes the transaction this cycle.
- `bus_rdata` in 32: read word, valid with `bus_ready` on loads.

## Operation
- FSM states: IDLE, BUS, DONE. Reset → IDLE.
- IDLE:
  - `req_valid` & aligned → latch request and bus fields, go to BUS; `stall_m`=1.
  - `req_valid` & misaligned → stay in IDLE; `misalign_m`=1, `stall_m`=0, `rdata_m`=0 (combinational, same cycle).
  - No request → `stall_m`=0.
- Misaligned means: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. Byte accesses are never misaligned.
- BUS: `bus_valid`=1, `stall_m`=1. On `bus_ready`, capture the extended read data and go to DONE.
- DONE: `stall_m`=0 so the pipeline advances; `rdata_m` holds the captured value. Next state is IDLE unconditionally.
- Request inputs are sampled only in IDLE. A change of `req_*` during BUS or DONE has no effect.
- Store strobes:
  - sb: `wstrb = 1<<addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - sh: `wstrb = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - sw: `wstrb = 1111`.
- Load extract: select the lane by `addr[1:0]`, then sign-extend (000, 001) or zero-extend (100, 101). Word loads pass through.
- Undefined `funct3` (011, 110, 111) is treated as a word access, including the alignment check.
- `rdata_m` is 0 for stores.

## Timing
- Reset values:
  - State IDLE.
  - `bus_valid`, `bus_write`, `bus_wstrb`, `bus_addr`, `bus_wdata` = 0.
  - `rdata_m` = 0, `bus_err_m` = 0.
  - `stall_m` and `misalign_m` follow their combinational rules (0 with `req_valid`=0).
- `bus_*` outputs are registered. They are stable from the first `bus_valid` cycle until `bus_ready` is sampled high, and `bus_valid` falls the cycle after `bus_ready`.
- Latency, request in cycle 0 with a zero-wait slave (`bus_ready` high in cycle 1): DONE in cycle 2. That is 2 stall cycles; each slave wait cycle adds one.
- Back-to-back requests: DONE → IDLE → BUS, so the minimum issue interval is 3 cycles.
- `rst` asserted mid-BUS drops `bus_valid` immediately and abandons the transaction; the slave must tolerate it.

## Configuration
- `DMEM_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter runs in BUS and is cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` without `bus_ready`, the FSM goes to DONE with `bus_err_m`=1 and `rdata_m`=0. `bus_err_m` is high for that DONE cycle only.
- Undefined: no counter; BUS waits indefinitely; `bus_err_m` is tied to 0.

## Test plan
- lb at 0x103 with `bus_rdata`=0x80FF_1234, zero wait → `rdata_m`=0xFFFF_FF80 in the DONE cycle; `stall_m` high exactly 2 cycles; `bus_addr`=0x100, `bus_wstrb`=0000.
- sh at 0x202 with `wdata`=0x0000_ABCD, 3 wait cycles → `bus_wstrb`=1100, `bus_wdata`=0xABCD_ABCD, `bus_valid` high 4 cycles with fields stable, `stall_m` high 5 cycles.
- lw at 0x006 → `misalign_m`=1, `stall_m`=0 same cycle, no `bus_valid`; lhu at 0x012 with `bus_rdata`=0xF00D_0000 → `rdata_m`=0x0000_F00D.
- Back-to-back sw 0x40 then lbu 0x41 → second `bus_valid` starts 3 cycles after the first; the lbu returns byte 1 zero-extended.
- `rst` pulsed in the second BUS cycle → `bus_valid`=0 and `stall_m`=0 while `rst` is high; a fresh request after release completes normally.
- With `DMEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, and `bus_ready` never asserted → DONE after 4 BUS cycles with `bus_err_m`=1 for one cycle and `rdata_m`=0.
